// File: rtl/ps2_keyboard_ctrl_pkg.sv
// rtl/ps2_keyboard_ctrl_pkg.sv - shared constants, state encodings and helpers
// Purpose: PS/2 keyboard command/response bytes, controller state encodings,
//          byte and state classification helpers.
// Ports:   none (package)
package ps2_keyboard_ctrl_pkg;

  // Host-to-keyboard commands
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;

  // Keyboard-to-host responses
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_ECHO     = 8'hEE;

  // Controller states
  localparam logic [3:0] RST_SEND    = 4'd0;
  localparam logic [3:0] RST_ACK     = 4'd1;
  localparam logic [3:0] RST_BAT     = 4'd2;
  localparam logic [3:0] IDLE        = 4'd3;
  localparam logic [3:0] LED_CMD     = 4'd4;
  localparam logic [3:0] LED_CMD_ACK = 4'd5;
  localparam logic [3:0] LED_VAL     = 4'd6;
  localparam logic [3:0] LED_VAL_ACK = 4'd7;
  localparam logic [3:0] ERROR       = 4'd8;

  // States that wait for a keyboard response and run the timeout
  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == RST_ACK) || (s == RST_BAT) || (s == LED_CMD_ACK) || (s == LED_VAL_ACK);
  endfunction

  // Protocol responses are consumed by the controller; everything else is a scancode
  function automatic logic is_scancode(input logic [7:0] b);
    return !((b == RSP_ACK) || (b == RSP_RESEND) || (b == RSP_ECHO));
  endfunction

endpackage

// File: rtl/ps2_keyboard_ctrl_if.sv
// rtl/ps2_keyboard_ctrl_if.sv - controller <-> PS/2 transceiver byte interface
// Purpose: groups the byte-level handshake with the PS/2 transceiver.
// Signals: ps2_write/ps2_tx_data  controller -> transceiver transmit request
//          ps2_read/ps2_rx_data   transceiver -> controller received byte pulse
//          ps2_busy               transceiver not idle
// Modports: master = controller side, slave = transceiver side
interface ps2_keyboard_ctrl_if;
  logic       ps2_write;
  logic [7:0] ps2_tx_data;
  logic       ps2_read;
  logic [7:0] ps2_rx_data;
  logic       ps2_busy;

  modport master (output ps2_write, ps2_tx_data, input ps2_read, ps2_rx_data, ps2_busy);
  modport slave  (input ps2_write, ps2_tx_data, output ps2_read, ps2_rx_data, ps2_busy);
endinterface

// File: rtl/ps2_timeout.sv
// rtl/ps2_timeout.sv - response timeout down-counter
// Purpose: holds LOAD_VALUE while load=1, counts down while enable=1,
//          flags expiry once the count reaches zero.
// Ports:   clk, rst (sync, active high), load, enable in; expired out
module ps2_timeout #(
  parameter int              WIDTH      = 24,
  parameter logic [WIDTH-1:0] LOAD_VALUE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= LOAD_VALUE;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = enable && (count == '0);
endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// rtl/ps2_keyboard_ctrl.sv - PS/2 keyboard initialisation, LED update and scancode controller
// Purpose: resets the keyboard (0xFF, expect 0xFA then 0xAA), services LED update
//          requests (0xED + value), forwards scancodes, retries on 0xFE/timeout.
// Ports:   clk, rst            clock, sync active-high reset
//          ps2 (master)        byte handshake with the PS/2 transceiver
//          led_req, led_val    LED update request and {caps, num, scroll}
//          led_ack             one-cycle pulse when the LED update completes
//          code_valid, code    forwarded scancode byte (latency 1 from ps2_read)
//          ready, error        keyboard initialised / sticky failure
module ps2_keyboard_ctrl
  import ps2_keyboard_ctrl_pkg::*;
#(
  parameter logic [23:0] RESP_TIMEOUT = 24'd12000000,
  parameter logic [1:0]  MAX_RETRY    = 2'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  ps2_keyboard_ctrl_if.master  ps2,
  input  logic                 led_req,
  input  logic [2:0]           led_val,
  output logic                 led_ack,
  output logic                 code_valid,
  output logic [7:0]           code,
  output logic                 ready,
  output logic                 error
);
  logic [3:0] state;
  logic [1:0] retry_cnt;
  logic [2:0] led_latch;
  logic       in_wait;
  logic       tmo_expired;
  logic       step_done;
  logic       resend;
  logic       forward;
  logic [7:0] send_byte;
  logic [3:0] ack_state;
  logic [3:0] retry_state;
  logic [7:0] rx;

  assign rx = ps2.ps2_rx_data;

  // Held loaded outside wait states; the extra reload on step_done covers
  // the direct wait-to-wait step RST_ACK -> RST_BAT.
  ps2_timeout #(
    .WIDTH      (24),
    .LOAD_VALUE (RESP_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (!in_wait || step_done),
    .enable  (in_wait),
    .expired (tmo_expired)
  );

  always_comb begin
    in_wait     = is_wait_state(state);
    send_byte   = CMD_RESET;
    ack_state   = RST_ACK;
    retry_state = RST_SEND;
    case (state)
      LED_CMD:     begin send_byte = CMD_SET_LED;         ack_state = LED_CMD_ACK; end
      LED_VAL:     begin send_byte = {5'b0, led_latch};   ack_state = LED_VAL_ACK; end
      LED_CMD_ACK: retry_state = LED_CMD;
      LED_VAL_ACK: retry_state = LED_VAL;
      default:     ;
    endcase

    step_done = 1'b0;
    if (ps2.ps2_read) begin
      case (state)
        RST_ACK, LED_CMD_ACK, LED_VAL_ACK: step_done = (rx == RSP_ACK);
        RST_BAT:                           step_done = (rx == RSP_BAT_OK);
        default:                           ;
      endcase
    end

    // A received byte masks a simultaneous expiry; the counter stays at zero,
    // so an unrelated byte only delays the resend by one cycle.
    resend = in_wait && (ps2.ps2_read
                         ? ((rx == RSP_RESEND) || ((state == RST_BAT) && (rx == RSP_BAT_FAIL)))
                         : tmo_expired);

    forward = ps2.ps2_read && is_scancode(rx) &&
              ((state == IDLE) || (state == LED_CMD) || (state == LED_CMD_ACK) ||
               (state == LED_VAL) || (state == LED_VAL_ACK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RST_SEND;
      retry_cnt       <= '0;
      led_latch       <= '0;
      ps2.ps2_write   <= 1'b0;
      ps2.ps2_tx_data <= '0;
      led_ack         <= 1'b0;
      code_valid      <= 1'b0;
      code            <= '0;
    end else begin
      led_ack    <= 1'b0;
      code_valid <= forward;
      if (forward) begin
        code <= rx;
      end

      case (state)
        RST_SEND, LED_CMD, LED_VAL: begin
          if (!ps2.ps2_write && !ps2.ps2_busy) begin
            ps2.ps2_write   <= 1'b1;
            ps2.ps2_tx_data <= send_byte;
          end else if (ps2.ps2_write && ps2.ps2_busy) begin
            ps2.ps2_write <= 1'b0;
            state         <= ack_state;
          end
        end

        RST_ACK, RST_BAT, LED_CMD_ACK, LED_VAL_ACK: begin
          if (step_done) begin
            retry_cnt <= '0;
            case (state)
              RST_ACK:     state <= RST_BAT;
              LED_CMD_ACK: state <= LED_VAL;
              LED_VAL_ACK: begin state <= IDLE; led_ack <= 1'b1; end
              default:     state <= IDLE;
            endcase
          end else if (resend) begin
            if (retry_cnt == MAX_RETRY) begin
              state <= ERROR;
            end else begin
              retry_cnt <= retry_cnt + 2'd1;
              state     <= retry_state;
            end
          end
        end

        IDLE: begin
          // The requester still holds led_req during the led_ack cycle;
          // do not take that as a fresh request.
          if (led_req && !led_ack) begin
            led_latch <= led_val;
            state     <= LED_CMD;
          end
        end

        ERROR: ;

        default: state <= RST_SEND;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign error = (state == ERROR);
endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// tb/tb_ps2_keyboard_ctrl.sv - self-checking bench for ps2_keyboard_ctrl
module tb_ps2_keyboard_ctrl;
  localparam int T         = 100;
  localparam int MAX_RETRY = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       led_req;
  logic [2:0] led_val;
  logic       led_ack;
  logic       code_valid;
  logic [7:0] code;
  logic       ready;
  logic       error;

  ps2_keyboard_ctrl_if bus();

  ps2_keyboard_ctrl #(
    .RESP_TIMEOUT (24'd100),
    .MAX_RETRY    (2'd3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2        (bus),
    .led_req    (led_req),
    .led_val    (led_val),
    .led_ack    (led_ack),
    .code_valid (code_valid),
    .code       (code),
    .ready      (ready),
    .error      (error)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         led_ack_cnt = 0;
  int         tx_rd   = 0;
  bit         fwd_mode;
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         fall_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Transceiver model: logs each requested byte, then plays out a frame of random length
  initial begin
    bus.ps2_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ps2_write === 1'b1 && !bus.ps2_busy) begin
        tx_log.push_back(bus.ps2_tx_data);
        tx_cyc.push_back(cyc);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.ps2_busy = 1'b1;
        @(negedge clk);
        fall_cyc.push_back(cyc);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        bus.ps2_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every wait in the main thread goes through here, so the LED requester
  // reacts to led_ack on the very cycle it appears.
  task automatic tick();
    @(negedge clk);
    if (led_ack === 1'b1) begin
      led_ack_cnt++;
      led_req = 1'b0;
    end
  endtask

  task automatic expect_tx(input logic [7:0] exp, input string tag);
    int n = 0;
    while (!((tx_log.size() > tx_rd) && bus.ps2_write === 1'b0 && !bus.ps2_busy) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      chk({tag, "_no_tx"}, 32'd0, 32'd1);
    end else begin
      chk(tag, tx_log[tx_rd], exp);
      tx_rd++;
    end
  endtask

  // Reference rule: a byte is forwarded only outside reset/error and when it is
  // not one of the protocol responses 0xFA/0xFE/0xEE.
  task automatic send_rx(input logic [7:0] b);
    logic exp_fwd;
    exp_fwd = fwd_mode && !(b == 8'hFA || b == 8'hFE || b == 8'hEE);
    bus.ps2_rx_data = b;
    bus.ps2_read    = 1'b1;
    tick();
    bus.ps2_read    = 1'b0;
    chk("code_valid_lat1", code_valid, exp_fwd);
    if (exp_fwd) chk("code_value", code, b);
    tick();
    chk("code_valid_pulse", code_valid, 1'b0);
  endtask

  task automatic do_init(input bit junk);
    fwd_mode = 1'b0;
    expect_tx(8'hFF, "init_reset_cmd");
    send_rx(8'hFA);
    if (junk) send_rx(8'h1C);
    chk("init_not_ready", ready, 1'b0);
    send_rx(8'hAA);
    chk("init_ready", ready, 1'b1);
    fwd_mode = 1'b1;
  endtask

  task automatic do_led(input logic [2:0] val, input int nc, input int nv);
    logic [7:0] exp_val;
    int a0;
    exp_val = {5'b0, val};
    led_val = val;
    led_req = 1'b1;
    expect_tx(8'hED, "led_cmd");
    led_val = ~val;
    for (int i = 0; i < nc; i++) begin
      send_rx(8'hFE);
      expect_tx(8'hED, "led_cmd_retx");
    end
    send_rx(8'hFA);
    expect_tx(exp_val, "led_val");
    for (int i = 0; i < nv; i++) begin
      send_rx(8'hFE);
      expect_tx(exp_val, "led_val_retx");
    end
    a0 = led_ack_cnt;
    send_rx(8'hFA);
    repeat (8) tick();
    chk("led_ack_once", led_ack_cnt - a0, 1);
    chk("led_ready", ready, 1'b1);
    chk("led_no_reaccept", tx_log.size() - tx_rd, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] sc[4];
    logic [7:0] b;
    int d;
    sc = '{8'h1C, 8'hF0, 8'h1C, 8'hFA};
    rst = 1'b1;
    led_req = 1'b0;
    led_val = 3'b000;
    bus.ps2_read = 1'b0;
    bus.ps2_rx_data = 8'h00;
    fwd_mode = 1'b0;
    repeat (3) tick();
    chk("rst_write", bus.ps2_write, 1'b0);
    chk("rst_tx_data", bus.ps2_tx_data, 8'h00);
    chk("rst_led_ack", led_ack, 1'b0);
    chk("rst_code_valid", code_valid, 1'b0);
    chk("rst_code", code, 8'h00);
    chk("rst_ready", ready, 1'b0);
    chk("rst_error", error, 1'b0);
    rst = 1'b0;
    do_init(1'b1);

    // Directed scancodes, then the directed LED update
    for (int i = 0; i < 4; i++) send_rx(sc[i]);
    do_led(3'b101, 0, 0);

    // Randomised mix of scancodes and LED updates with up to MAX_RETRY resends per byte
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        b = 8'($urandom_range(0, 255));
        send_rx(b);
      end else begin
        do_led(3'($urandom_range(0, 7)), $urandom_range(0, MAX_RETRY), $urandom_range(0, MAX_RETRY));
      end
    end

    // Reset while waiting for the LED value acknowledge
    send_rx(8'h5A);
    led_val = 3'b011;
    led_req = 1'b1;
    expect_tx(8'hED, "mid_cmd");
    send_rx(8'hFA);
    expect_tx(8'h03, "mid_val");
    rst = 1'b1;
    led_req = 1'b0;
    tick();
    chk("mid_rst_write", bus.ps2_write, 1'b0);
    chk("mid_rst_tx_data", bus.ps2_tx_data, 8'h00);
    chk("mid_rst_led_ack", led_ack, 1'b0);
    chk("mid_rst_code_valid", code_valid, 1'b0);
    chk("mid_rst_code", code, 8'h00);
    chk("mid_rst_ready", ready, 1'b0);
    chk("mid_rst_error", error, 1'b0);
    rst = 1'b0;
    do_init(1'b0);

    // Resend exhaustion on the LED command
    led_val = 3'b110;
    led_req = 1'b1;
    expect_tx(8'hED, "nak_first");
    send_rx(8'hFE);
    expect_tx(8'hED, "nak_retx");
    for (int i = 0; i < MAX_RETRY; i++) begin
      send_rx(8'hFE);
      if (i < MAX_RETRY - 1) expect_tx(8'hED, "nak_retx");
    end
    chk("nak_error", error, 1'b1);
    chk("nak_not_ready", ready, 1'b0);
    fwd_mode = 1'b0;
    send_rx(8'h2B);
    repeat (20) tick();
    chk("nak_no_tx", tx_log.size() - tx_rd, 0);
    chk("nak_error_sticky", error, 1'b1);

    // Timeout exhaustion on the reset command
    rst = 1'b1;
    led_req = 1'b0;
    repeat (2) tick();
    chk("tmo_rst_error", error, 1'b0);
    rst = 1'b0;
    for (int i = 0; i <= MAX_RETRY; i++) begin
      expect_tx(8'hFF, "tmo_reset_cmd");
      if (i > 0) begin
        d = tx_cyc[tx_rd - 1] - fall_cyc[tx_rd - 2];
        chk("tmo_interval", (d >= T && d <= T + 4), 1'b1);
      end
    end
    repeat (T + 20) tick();
    chk("tmo_error", error, 1'b1);
    chk("tmo_not_ready", ready, 1'b0);
    chk("tmo_no_tx", tx_log.size() - tx_rd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
